// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store request/response bus between the CPU and dmem.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Wait-state data-memory target with RV32I byte/half/word access.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [1:0] C_SIZE_B = 2'b00;
  localparam logic [1:0] C_SIZE_H = 2'b01;
  localparam logic [1:0] C_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_accept, w_access, w_retire;
  logic             w_req_ready, w_rsp_valid;

  logic             r_we;
  logic [31:0]      r_addr;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic [31:0]       r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_wlanes;
  logic [3:0]        w_be;
  logic              w_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_retire    = 1'b0;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = ~reset;
        if (bus.req_valid && !reset) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = C_CNT_INIT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // ---------------------------------------------------------------- decode
  assign w_err = (r_size == 2'b11)
              || (r_size == C_SIZE_H && r_addr[0])
              || (r_size == C_SIZE_W && r_addr[1:0] != 2'b00)
              || (|r_addr[31:ADDR_W+2]);

  assign w_idx  = r_addr[ADDR_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_load = w_word;
    case (r_size)
      C_SIZE_B: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      C_SIZE_H: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default:  w_load = w_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    w_wlanes = r_wdata;
    w_be     = 4'b1111;
    case (r_size)
      C_SIZE_B: begin
        w_wlanes = {4{r_wdata[7:0]}};
        w_be     = 4'b0001 << r_addr[1:0];
      end
      C_SIZE_H: begin
        w_wlanes = {2{r_wdata[15:0]}};
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wlanes = r_wdata;
        w_be     = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_addr     <= bus.req_addr;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_wdata    <= bus.req_wdata;
      end
      if (w_access) begin
        r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
      if (w_retire) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Backing RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  dmem_responder_if bus();

  dmem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction; request fields are scrambled after accept.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    bit acc;
    int lat;
    acc = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ":accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_addr     = ~addr;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    bus.req_wdata    = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, ":latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    chk({tag, ":rdata"},   bus.rsp_rdata, exp_rdata);
    chk({tag, ":err"},     32'(bus.rsp_err), 32'(exp_err));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ":retire"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst:req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst:rdata",     bus.rsp_rdata,      32'd0);
    chk("rst:err",       32'(bus.rsp_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst:ready_after", 32'(bus.req_ready), 32'd1);

    // Prefill words that later readbacks depend on.
    txn("sw0_0",   1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    txn("sw0_20",  1'b1, 32'h0000_0020, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 1'b0);

    txn("sw_10",   1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    txn("lw_10",   1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn("sb_13",   1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'h1234_567F, 32'd0, 1'b0);
    txn("lb_13",   1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         32'h0000_007F, 1'b0);
    txn("lw_10b",  1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'h7FAD_BEEF, 1'b0);
    txn("lb_12",   1'b0, 32'h0000_0012, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFAD, 1'b0);
    txn("lbu_12",  1'b0, 32'h0000_0012, 2'b00, 1'b1, 32'h0,         32'h0000_00AD, 1'b0);
    txn("lh_10",   1'b0, 32'h0000_0010, 2'b01, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0);
    txn("lwu_10",  1'b0, 32'h0000_0010, 2'b10, 1'b1, 32'h0,         32'h7FAD_BEEF, 1'b0);

    txn("sh_22",   1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h5555_8001, 32'd0, 1'b0);
    txn("lh_22",   1'b0, 32'h0000_0022, 2'b01, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0);
    txn("lhu_22",  1'b0, 32'h0000_0022, 2'b01, 1'b1, 32'h0,         32'h0000_8001, 1'b0);
    txn("lb_23",   1'b0, 32'h0000_0023, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0);
    txn("lbu_22",  1'b0, 32'h0000_0022, 2'b00, 1'b1, 32'h0,         32'h0000_0001, 1'b0);
    txn("lw_20",   1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0,         32'h8001_0000, 1'b0);

    // Faulting requests followed by readbacks proving RAM is untouched.
    txn("e_lw_11",  1'b0, 32'h0000_0011, 2'b10, 1'b0, 32'h0,         32'd0, 1'b1);
    txn("e_sh_21",  1'b1, 32'h0000_0021, 2'b01, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1);
    txn("rb_20",    1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0,         32'h8001_0000, 1'b0);
    txn("e_ld_s3",  1'b0, 32'h0000_0010, 2'b11, 1'b0, 32'h0,         32'd0, 1'b1);
    txn("e_st_s3",  1'b1, 32'h0000_0010, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 1'b1);
    txn("rb_10",    1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'h7FAD_BEEF, 1'b0);
    txn("e_sw_oor", 1'b1, 32'h0000_1000, 2'b10, 1'b0, 32'h1111_1111, 32'd0, 1'b1);
    txn("e_lw_oor", 1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0,         32'd0, 1'b1);
    txn("e_lw_hi",  1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0,         32'd0, 1'b1);
    txn("rb_0",     1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0,         32'd0, 1'b0);

    // Backpressure: response held, a competing request is neither accepted nor queued.
    @(negedge clk);
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0010;
    bus.req_size  = 2'b10;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) break;
      @(posedge clk);
      #1;
    end
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0000_0000;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp:rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp:rdata",     bus.rsp_rdata,      32'h7FAD_BEEF);
      chk("bp:req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("bp:idle_after_retire", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
    bus.req_valid = 1'b0;
    txn("bp:rb_10", 1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, 32'h7FAD_BEEF, 1'b0);

    // Reset during the wait phase of a store.
    txn("sw_40", 1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b0);
    @(negedge clk);
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0040;
    bus.req_size  = 2'b10;
    bus.req_wdata = 32'h1234_5678;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw:ready_in_reset", 32'(bus.req_ready), 32'd0);
    chk("rw:valid_in_reset", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rw:no_rsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
    end
    txn("rw:rb_40", 1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
